// File: rtl/trig_tx_serializer.sv
// trig_tx_serializer: one 8-bit frame per BX -> 2-bit/cycle DDR stream + SOF, delayable 0..7 bits; TX_PRBS_EN adds PRBS7 payload.
// Latency 1 cycle from accept (+delay/2); frame_ready_o only at phase 3, a missing frame inserts IDLE_PATTERN.
module trig_tx_serializer #(
   parameter logic [7:0] IDLE_PATTERN = 8'h00,
   parameter int         CNT_WIDTH    = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [7:0]           frame_i,
   input  logic                 frame_valid_i,
   output logic                 frame_ready_o,
   input  logic [2:0]           delay_sel_i,
   input  logic                 prbs_en_i,
   input  logic                 cnt_reset_i,
   output logic                 d0,
   output logic                 d1,
   output logic                 sof_d0,
   output logic                 sof_d1,
   output logic [1:0]           phase_o,
   output logic [CNT_WIDTH-1:0] frames_cnt,
   output logic [CNT_WIDTH-1:0] underrun_cnt
);

   logic [1:0]           phase_q, phase_d;
   logic [7:0]           frame_q, frame_d;
   logic [2:0]           delay_q, delay_d;
   logic [15:0]          hist_q, hist_d;
   logic [15:0]          sofh_q, sofh_d;
   logic                 d0_q, d1_q, sof0_q, sof1_q, rdy_q;
   logic [CNT_WIDTH-1:0] frames_q, frames_d, under_q, under_d;
   logic                 load, accept, underrun;
   logic [7:0]           load_frame;
   logic [1:0]           pair;
   logic [3:0]           tap_lo, tap_hi;

`ifdef TX_PRBS_EN
   logic [6:0] prbs_q, prbs_d, prbs_s;
   logic [7:0] prbs_byte;

   // Bit i of the loaded byte is the i-th generated bit, so bit 0 goes out first.
   always_comb begin
      prbs_s    = prbs_q;
      prbs_byte = '0;
      for (int i = 0; i < 8; i++) begin
         prbs_byte[i] = prbs_s[6] ^ prbs_s[5];
         prbs_s       = {prbs_s[5:0], prbs_byte[i]};
      end
      prbs_d = (load && prbs_en_i) ? prbs_s : prbs_q;
   end
`else
   logic unused_prbs_en;
   assign unused_prbs_en = prbs_en_i;
`endif

   always_comb begin
      phase_d    = phase_q + 2'd1;
      load       = (phase_q == 2'd3);
      accept     = load && frame_valid_i;
      underrun   = load && !frame_valid_i;
      load_frame = frame_valid_i ? frame_i : IDLE_PATTERN;
`ifdef TX_PRBS_EN
      if (prbs_en_i) begin
         load_frame = prbs_byte;
         accept     = load;
         underrun   = 1'b0;
      end
`endif
      frame_d = load ? load_frame : frame_q;
      delay_d = load ? delay_sel_i : delay_q;

      // On a load phase_d is 0, so the new frame's bits 0/1 enter the history in the same edge.
      pair   = frame_d[{phase_d, 1'b0} +: 2];
      hist_d = {hist_q[13:0], pair[0], pair[1]};
      sofh_d = {sofh_q[13:0], load, 1'b0};

      // Index 0 is the newest (later) bit; older bits sit at higher indices.
      tap_lo = {1'b0, delay_d};
      tap_hi = tap_lo + 4'd1;

      if (cnt_reset_i)
         frames_d = '0;
      else if (accept && !(&frames_q))
         frames_d = frames_q + 1'b1;
      else
         frames_d = frames_q;

      if (cnt_reset_i)
         under_d = '0;
      else if (underrun && !(&under_q))
         under_d = under_q + 1'b1;
      else
         under_d = under_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q  <= 2'd0;
         frame_q  <= 8'h00;
         delay_q  <= 3'd0;
         hist_q   <= 16'h0000;
         sofh_q   <= 16'h0000;
         d0_q     <= 1'b0;
         d1_q     <= 1'b0;
         sof0_q   <= 1'b0;
         sof1_q   <= 1'b0;
         rdy_q    <= 1'b0;
         frames_q <= '0;
         under_q  <= '0;
`ifdef TX_PRBS_EN
         prbs_q   <= 7'h7F;
`endif
      end else begin
         phase_q  <= phase_d;
         frame_q  <= frame_d;
         delay_q  <= delay_d;
         hist_q   <= hist_d;
         sofh_q   <= sofh_d;
         d0_q     <= hist_d[tap_hi];
         d1_q     <= hist_d[tap_lo];
         sof0_q   <= sofh_d[tap_hi];
         sof1_q   <= sofh_d[tap_lo];
         rdy_q    <= (phase_d == 2'd3);
         frames_q <= frames_d;
         under_q  <= under_d;
`ifdef TX_PRBS_EN
         prbs_q   <= prbs_d;
`endif
      end
   end

   // The deepest tap is index 8; the top history bits are kept only for depth symmetry.
   logic unused_hist;
   assign unused_hist = ^{hist_q[15:14], sofh_q[15:14]};

   assign frame_ready_o = rdy_q;
   assign d0            = d0_q;
   assign d1            = d1_q;
   assign sof_d0        = sof0_q;
   assign sof_d1        = sof1_q;
   assign phase_o       = phase_q;
   assign frames_cnt    = frames_q;
   assign underrun_cnt  = under_q;

endmodule

// File: tb/tb_trig_tx_serializer.sv
// Scoreboard bench for trig_tx_serializer: directed frames push hand-computed per-cycle outputs, a negedge monitor compares.
module tb_trig_tx_serializer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  frame_i = 8'h00;
   logic        frame_valid_i = 1'b0;
   logic        frame_ready_o;
   logic [2:0]  delay_sel_i = 3'd0;
   logic        prbs_en_i = 1'b0;
   logic        cnt_reset_i = 1'b0;
   logic        d0, d1, sof_d0, sof_d1;
   logic [1:0]  phase_o;
   logic [15:0] frames_cnt, underrun_cnt;

   trig_tx_serializer dut (
      .clock         (clock),
      .reset         (reset),
      .frame_i       (frame_i),
      .frame_valid_i (frame_valid_i),
      .frame_ready_o (frame_ready_o),
      .delay_sel_i   (delay_sel_i),
      .prbs_en_i     (prbs_en_i),
      .cnt_reset_i   (cnt_reset_i),
      .d0            (d0),
      .d1            (d1),
      .sof_d0        (sof_d0),
      .sof_d1        (sof_d1),
      .phase_o       (phase_o),
      .frames_cnt    (frames_cnt),
      .underrun_cnt  (underrun_cnt)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Expected word: {phase, ready, d0, d1, sof_d0, sof_d1}
   typedef struct {
      int         cyc;
      logic [6:0] v;
   } exp_t;
   exp_t sb[$];

   task automatic push(input int c, input logic [1:0] ph, input logic [3:0] o);
      exp_t e;
      e.cyc = c;
      e.v   = {ph, (ph == 2'd3), o};
      sb.push_back(e);
   endtask

   always @(negedge clock) begin
      exp_t       e;
      logic [6:0] act;
      act = {phase_o, frame_ready_o, d0, d1, sof_d0, sof_d1};
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         checks++;
         if (e.cyc != cyc) begin
            failures++;
            $display("FAIL stream_missed cyc=%0d actual_cyc=%0d required_cyc=%0d", cyc, cyc, e.cyc);
         end else if (act !== e.v) begin
            failures++;
            $display("FAIL stream cyc=%0d actual={ph,rdy,d0,d1,s0,s1}=%b required=%b", cyc, act, e.v);
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Called in a phase-3 cycle; returns in the next phase-3 cycle.
   task automatic do_frame(input logic [7:0] f, input logic vld, input logic [2:0] dly,
                           input logic clr, input int dly_ph1, input logic [15:0] e);
      frame_i       = f;
      frame_valid_i = vld;
      delay_sel_i   = dly;
      cnt_reset_i   = clr;
      for (int k = 0; k < 4; k++) push(cyc + 1 + k, 2'(k), e[15-4*k -: 4]);
      step();
      cnt_reset_i = 1'b0;
      step();
      if (dly_ph1 >= 0) delay_sel_i = 3'(dly_ph1);
      step();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1);
   end

`ifdef TX_PRBS_EN
   logic [6:0]  ps;
   logic [7:0]  pb;
   logic [15:0] pe;
`endif

   initial begin
      // Reset state
      step();
      step();
      push(cyc, 2'd0, 4'h0);
      chk("rst_frames_cnt", int'(frames_cnt), 0);
      chk("rst_underrun_cnt", int'(underrun_cnt), 0);
      step();
      reset = 1'b0;
      push(cyc, 2'd0, 4'h0);
      step(); push(cyc, 2'd1, 4'h0);
      step(); push(cyc, 2'd2, 4'h0);
      step(); push(cyc, 2'd3, 4'h0);

      // Basic pattern
      do_frame(8'hA5, 1'b1, 3'd0, 1'b0, -1, 16'hA844);
      chk("basic_frames_cnt", int'(frames_cnt), 1);

      // Odd delay moves SOF to d1
      do_frame(8'h00, 1'b1, 3'd1, 1'b0, -1, 16'h9000);
      do_frame(8'hA5, 1'b1, 3'd1, 1'b0, -1, 16'h5408);
      chk("odd_frames_cnt", int'(frames_cnt), 3);
      chk("odd_underrun_cnt", int'(underrun_cnt), 0);

      // Underruns insert idle frames with SOF
      for (int i = 0; i < 3; i++) do_frame(8'h77, 1'b0, 3'd0, 1'b0, -1, 16'h2000);
      chk("underrun_cnt", int'(underrun_cnt), 3);
      chk("underrun_frames_cnt", int'(frames_cnt), 3);

      // Counter clear coincides with an accepted frame: clear wins
      do_frame(8'h3C, 1'b1, 3'd0, 1'b1, -1, 16'h2CC0);
      chk("clr_frames_cnt", int'(frames_cnt), 0);
      chk("clr_underrun_cnt", int'(underrun_cnt), 0);

      // Delay 0->3 requested at phase 1: current frame untouched, then 3 bits repeat
      do_frame(8'hA5, 1'b1, 3'd0, 1'b0, 3, 16'hA844);
      do_frame(8'hC3, 1'b1, 3'd3, 1'b0, -1, 16'h8D80);
      do_frame(8'h00, 1'b1, 3'd3, 1'b0, -1, 16'h4900);
      chk("dly_frames_cnt", int'(frames_cnt), 3);

      // Reset at phase 2 of an 8'hFF frame
      frame_i       = 8'hFF;
      frame_valid_i = 1'b1;
      delay_sel_i   = 3'd0;
      push(cyc + 1, 2'd0, 4'hE);
      push(cyc + 2, 2'd1, 4'hC);
      push(cyc + 3, 2'd2, 4'hC);
      step(); step(); step();
      reset = 1'b1;
      step();
      push(cyc, 2'd0, 4'h0);
      reset = 1'b0;
      chk("midrst_frames_cnt", int'(frames_cnt), 0);
      step(); push(cyc, 2'd1, 4'h0);
      step(); push(cyc, 2'd2, 4'h0);
      step(); push(cyc, 2'd3, 4'h0);

      do_frame(8'h5A, 1'b1, 3'd0, 1'b0, -1, 16'h6488);
      chk("post_frames_cnt", int'(frames_cnt), 1);
      chk("post_underrun_cnt", int'(underrun_cnt), 0);

`ifdef TX_PRBS_EN
      // PRBS7 x^7+x^6+1 from seed 7F; frame_valid_i low must not count underruns
      prbs_en_i = 1'b1;
      ps = 7'h7F;
      for (int f = 0; f < 32; f++) begin
         for (int i = 0; i < 8; i++) begin
            pb[i] = ps[6] ^ ps[5];
            ps    = {ps[5:0], pb[i]};
         end
         pe = {pb[0], pb[1], 1'b1, 1'b0, pb[2], pb[3], 2'b00,
               pb[4], pb[5], 2'b00, pb[6], pb[7], 2'b00};
         do_frame(8'h00, 1'b0, 3'd0, 1'b0, -1, pe);
      end
      prbs_en_i = 1'b0;
      chk("prbs_underrun_cnt", int'(underrun_cnt), 0);
      chk("prbs_frames_cnt", int'(frames_cnt), 33);
`endif

      step();
      step();
      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
